// File: rtl/divu_seq_pkg.sv
// Shared definitions for the sequential unsigned divider.
// The operand width, FSM state encoding and iteration-counter width live here.
package divu_seq_pkg;

    localparam int XLEN  = 64;
    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/divu_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and produce the quotient bit.
module divu_step #(
    parameter int W = divu_seq_pkg::XLEN
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-1:0] dvs_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);

    logic [W:0] shifted;
    logic [W:0] diff;

    // The shifted remainder keeps the old MSB in bit W, so nothing is lost.
    // Since rem < B, shifted < 2B; diff[W] is therefore exactly the borrow.
    assign shifted = {rem_i, bit_i};
    assign diff    = shifted - {1'b0, dvs_i};
    assign q_o     = ~diff[W];
    assign rem_o   = diff[W] ? shifted[W-1:0] : diff[W-1:0];

endmodule

// File: rtl/divu_seq.sv
// Iterative unsigned divider, one quotient bit per clock, MSB first.
// Divide-by-zero returns all-ones quotient and the dividend as remainder.
module divu_seq #(
    parameter int XLEN = divu_seq_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Q,
    output logic [XLEN-1:0] R,
    output logic            div_by_zero,
    output logic [1:0]      dbg_state_o
);

    import divu_seq_pkg::*;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    rem_q, rem_d;
    logic [XLEN-1:0]    dvd_q, dvd_d;
    logic [XLEN-1:0]    dvs_q, dvs_d;
    logic [XLEN-1:0]    q_q, q_d;
    logic [XLEN-1:0]    r_q, r_d;
    logic               dbz_q, dbz_d;

    logic [XLEN-1:0]    step_rem;
    logic               step_q;
    logic               accept;

    divu_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .bit_i (dvd_q[XLEN-1]),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .q_o   (step_q)
    );

    assign accept = start && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        q_d     = q_q;
        r_d     = r_q;
        dbz_d   = dbz_q;
        case (state_q)
            RUN: begin
                // Dividend register doubles as quotient: bits shift out at the top, quotient bits in at the bottom.
                rem_d = step_rem;
                dvd_d = {dvd_q[XLEN-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    q_d     = {dvd_q[XLEN-2:0], step_q};
                    r_d     = step_rem;
                    dbz_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    if (B == '0) begin
                        state_d = DONE;
                        q_d     = '1;
                        r_d     = A;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = RUN;
                        dvd_d   = A;
                        dvs_d   = B;
                        rem_d   = '0;
                        cnt_d   = CNT_W'(XLEN - 1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            q_q     <= q_d;
            r_q     <= r_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = (state_q == DONE);
    assign Q           = q_q;
    assign R           = r_q;
    assign div_by_zero = dbz_q;
    assign dbg_state_o = state_q;

endmodule
